// File: rtl/uart_ext.sv
// uart_ext: full-duplex UART with run-time baud divisor, 16x oversampled majority-vote receiver,
// FWFT rx/tx FIFOs and sticky line errors. Parity support is built only when UART_PARITY_EN is defined.

module uart_ext_fifo #(
    parameter int width = 8,
    parameter int depth = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [width-1:0] data_i,
    input  logic             pop_i,
    output logic [width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] PTR_ONE = {{aw{1'b0}}, 1'b1};

    logic [width-1:0] mem [depth];
    logic [aw:0]      wptr_q, rptr_q;

    always_ff @(posedge clk) begin
        if (push_i) mem[wptr_q[aw-1:0]] <= data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PTR_ONE;
            if (pop_i)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    assign head_o  = mem[rptr_q[aw-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[aw] != rptr_q[aw]) && (wptr_q[aw-1:0] == rptr_q[aw-1:0]);
endmodule

module uart_ext #(
    parameter int data_width = 8,
    parameter int fifo_depth = 16,
    parameter int div_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  tx,
    input  logic [div_width-1:0]  baud_div,
    input  logic                  stop2,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    output logic [data_width-1:0] rdata,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [data_width-1:0] wdata,
    input  logic                  wvalid,
    output logic                  wready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun,
    input  logic                  err_clr,
    output logic                  tx_busy
);
    localparam logic [3:0] LAST_BIT = 4'(data_width - 1);
    localparam logic [div_width-1:0] DIV_ONE = {{(div_width-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;

    logic [div_width-1:0] div_cnt_q, div_cnt_d;
    logic tick;
    logic rx_meta_q, rx_sync_q;

    rx_state_t rx_state_q, rx_state_d;
    logic [3:0] rx_tick_q, rx_tick_d, rx_bit_q, rx_bit_d, rx_cnt_next;
    logic [data_width-1:0] rx_shift_q, rx_shift_d;
    logic rx_s7_q, rx_s7_d, rx_s8_q, rx_s8_d, rx_maj;
    logic rx_push, rx_pop, rx_full, rx_empty;
    logic [data_width-1:0] rx_head;
    logic frame_set, par_set, ovr_set;
    logic frame_err_q, parity_err_q, overrun_q;

    tx_state_t tx_state_q, tx_state_d;
    logic [3:0] tx_tick_q, tx_tick_d, tx_bit_q, tx_bit_d;
    logic [data_width-1:0] tx_shift_q, tx_shift_d;
    logic tx_stop2_q, tx_stop2_d, tx_q, tx_d;
    logic tx_pop, tx_full, tx_empty;
    logic [data_width-1:0] tx_head;

`ifdef UART_PARITY_EN
    logic rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d, rx_par_bad_q, rx_par_bad_d;
    logic tx_par_en_q, tx_par_en_d, tx_par_q, tx_par_d;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = parity_en ^ parity_odd;
`endif

    assign tick        = (div_cnt_q >= baud_div);
    assign div_cnt_d   = tick ? '0 : div_cnt_q + DIV_ONE;
    assign rx_cnt_next = rx_tick_q + 4'd1;
    assign rx_maj      = (rx_s7_q & rx_s8_q) | (rx_s7_q & rx_sync_q) | (rx_s8_q & rx_sync_q);

    uart_ext_fifo #(.width(data_width), .depth(fifo_depth)) u_rx_fifo (
        .clk(clk), .rst(rst), .push_i(rx_push), .data_i(rx_shift_q), .pop_i(rx_pop),
        .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty));

    uart_ext_fifo #(.width(data_width), .depth(fifo_depth)) u_tx_fifo (
        .clk(clk), .rst(rst), .push_i(wvalid && wready), .data_i(wdata), .pop_i(tx_pop),
        .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty));

    assign rvalid = !rx_empty;
    assign rdata  = rvalid ? rx_head : '0;
    assign rx_pop = rvalid && rready;
    assign wready = !tx_full;

    // Receiver: samples at oversample ticks 7,8,9 are voted; the stop bit is resolved at tick 9.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_s7_d    = rx_s7_q;
        rx_s8_d    = rx_s8_q;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        par_set    = 1'b0;
        ovr_set    = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_en_d  = rx_par_en_q;
        rx_par_odd_d = rx_par_odd_q;
        rx_par_bad_d = rx_par_bad_q;
`endif
        if (tick) begin
            if (rx_state_q == RX_IDLE) begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_tick_d  = 4'd0;
                    rx_bit_d   = 4'd0;
`ifdef UART_PARITY_EN
                    rx_par_en_d  = parity_en;
                    rx_par_odd_d = parity_odd;
                    rx_par_bad_d = 1'b0;
`endif
                end
            end else begin
                rx_tick_d = rx_cnt_next;
                if (rx_cnt_next == 4'd7) rx_s7_d = rx_sync_q;
                if (rx_cnt_next == 4'd8) rx_s8_d = rx_sync_q;
                case (rx_state_q)
                    RX_START: begin
                        if (rx_cnt_next == 4'd9 && rx_maj) rx_state_d = RX_IDLE;
                        else if (rx_tick_q == 4'd15)        rx_state_d = RX_DATA;
                    end
                    RX_DATA: begin
                        if (rx_cnt_next == 4'd9) rx_shift_d = {rx_maj, rx_shift_q[data_width-1:1]};
                        if (rx_tick_q == 4'd15) begin
                            rx_bit_d = rx_bit_q + 4'd1;
                            if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                                rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
`else
                                rx_state_d = RX_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_PARITY_EN
                    RX_PARITY: begin
                        if (rx_cnt_next == 4'd9) rx_par_bad_d = ((^rx_shift_q) ^ rx_maj) != rx_par_odd_q;
                        if (rx_tick_q == 4'd15)  rx_state_d = RX_STOP;
                    end
`endif
                    RX_STOP: begin
                        if (rx_cnt_next == 4'd9) begin
                            rx_state_d = RX_IDLE;
                            if (!rx_maj) frame_set = 1'b1;
`ifdef UART_PARITY_EN
                            else if (rx_par_bad_q) par_set = 1'b1;
`endif
                            else if (rx_full && !rx_pop) ovr_set = 1'b1;
                            else rx_push = 1'b1;
                        end
                    end
                    default: rx_state_d = RX_IDLE;
                endcase
            end
        end
    end

    // Transmitter: every state spans 16 ticks; tx is registered from the next state.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_stop2_d = tx_stop2_q;
        tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_en_d = tx_par_en_q;
        tx_par_d    = tx_par_q;
`endif
        if (tick) begin
            if (tx_state_q == TX_IDLE) begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = TX_START;
                    tx_tick_d  = 4'd0;
                    tx_bit_d   = 4'd0;
                    tx_shift_d = tx_head;
                    tx_stop2_d = stop2;
`ifdef UART_PARITY_EN
                    tx_par_en_d = parity_en;
                    tx_par_d    = (^tx_head) ^ parity_odd;
`endif
                end
            end else begin
                tx_tick_d = tx_tick_q + 4'd1;
                if (tx_tick_q == 4'd15) begin
                    case (tx_state_q)
                        TX_START: tx_state_d = TX_DATA;
                        TX_DATA: begin
                            tx_shift_d = tx_shift_q >> 1;
                            tx_bit_d   = tx_bit_q + 4'd1;
                            if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                                tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP1;
`else
                                tx_state_d = TX_STOP1;
`endif
                            end
                        end
                        TX_PARITY: tx_state_d = TX_STOP1;
                        TX_STOP1:  tx_state_d = tx_stop2_q ? TX_STOP2 : TX_IDLE;
                        default:   tx_state_d = TX_IDLE;
                    endcase
                end
            end
        end
        case (tx_state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_d = tx_par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q    <= '0;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_tick_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_s7_q      <= 1'b1;
            rx_s8_q      <= 1'b1;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            tx_state_q   <= TX_IDLE;
            tx_tick_q    <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_stop2_q   <= 1'b0;
            tx_q         <= 1'b1;
`ifdef UART_PARITY_EN
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_par_bad_q <= 1'b0;
            tx_par_en_q  <= 1'b0;
            tx_par_q     <= 1'b0;
`endif
        end else begin
            div_cnt_q    <= div_cnt_d;
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_state_q   <= rx_state_d;
            rx_tick_q    <= rx_tick_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_s7_q      <= rx_s7_d;
            rx_s8_q      <= rx_s8_d;
            frame_err_q  <= frame_set | (frame_err_q & ~err_clr);
            parity_err_q <= par_set | (parity_err_q & ~err_clr);
            overrun_q    <= ovr_set | (overrun_q & ~err_clr);
            tx_state_q   <= tx_state_d;
            tx_tick_q    <= tx_tick_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_stop2_q   <= tx_stop2_d;
            tx_q         <= tx_d;
`ifdef UART_PARITY_EN
            rx_par_en_q  <= rx_par_en_d;
            rx_par_odd_q <= rx_par_odd_d;
            rx_par_bad_q <= rx_par_bad_d;
            tx_par_en_q  <= tx_par_en_d;
            tx_par_q     <= tx_par_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign tx_busy    = (tx_state_q != TX_IDLE) || !tx_empty;
endmodule

// File: tb/tb_uart_ext.sv
// Directed bench for uart_ext: tx waveform, loopback, framing/false-start/overrun errors, async reset.
module tb_uart_ext;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx, tx, rx_drv, loop_en;
    logic [15:0] baud_div;
    logic        stop2, parity_en, parity_odd;
    logic [7:0]  rdata, wdata;
    logic        rvalid, rready, wvalid, wready;
    logic        frame_err, parity_err, overrun, err_clr, tx_busy;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    assign rx = loop_en ? tx : rx_drv;

    uart_ext dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .baud_div(baud_div), .stop2(stop2),
        .parity_en(parity_en), .parity_odd(parity_odd), .rdata(rdata), .rvalid(rvalid),
        .rready(rready), .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
        .err_clr(err_clr), .tx_busy(tx_busy));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
        $display("txn %s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    // One bit = 16 ticks * (baud_div+1) = 64 cycles at baud_div=3.
    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input logic use_par, input logic pbit);
        @(negedge clk) rx_drv = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (64) @(negedge clk);
        end
        if (use_par) begin
            rx_drv = pbit;
            repeat (64) @(negedge clk);
        end
        rx_drv = stop_v;
        repeat (64) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        @(negedge clk);
        wdata  = d;
        wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic read_byte(input logic [7:0] exp, input string tag);
        int n = 0;
        while (!rvalid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        check(tag, {24'd0, rdata}, {24'd0, exp});
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] a5;
        int n;
        a5 = 8'hA5;
        rst = 1'b1; rx_drv = 1'b1; loop_en = 1'b0; baud_div = 16'd3; stop2 = 1'b0;
        parity_en = 1'b0; parity_odd = 1'b0; rready = 1'b0; wdata = '0; wvalid = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd1);
        check("rst_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // tx waveform for 0xA5
        @(negedge clk);
        wdata = a5; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check("busy_after_accept", {31'd0, tx_busy}, 32'd1);
        n = 0;
        while (tx && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("start_latency", {31'd0, tx}, 32'd0);
        repeat (63) @(negedge clk);
        check("start_last", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("bit%0d_first", i), {31'd0, tx}, {31'd0, a5[i]});
            repeat (63) @(negedge clk);
            check($sformatf("bit%0d_last", i), {31'd0, tx}, {31'd0, a5[i]});
        end
        @(negedge clk);
        check("stop_first", {31'd0, tx}, 32'd1);
        repeat (63) @(negedge clk);
        check("stop_last", {31'd0, tx}, 32'd1);
        check("busy_in_stop", {31'd0, tx_busy}, 32'd1);
        repeat (2) @(negedge clk);
        check("busy_done", {31'd0, tx_busy}, 32'd0);

        // loopback of three bytes
        loop_en = 1'b1;
        write_byte(8'h00);
        write_byte(8'hFF);
        write_byte(8'h5A);
        read_byte(8'h00, "loop0");
        read_byte(8'hFF, "loop1");
        read_byte(8'h5A, "loop2");
        repeat (700) @(negedge clk);
        check("loop_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
        check("loop_empty", {31'd0, rvalid}, 32'd0);
        loop_en = 1'b0;

        // framing error
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        check("ferr_nopush", {31'd0, rvalid}, 32'd0);
        check("ferr_set", {31'd0, frame_err}, 32'd1);
        pulse_clr();
        check("ferr_clr", {31'd0, frame_err}, 32'd0);

        // false start: 16 cycles low is a quarter bit
        @(negedge clk) rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("false_start_rvalid", {31'd0, rvalid}, 32'd0);
        check("false_start_ferr", {31'd0, frame_err}, 32'd0);

        // overrun: 17 frames into a 16-entry rx FIFO
        for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        check("ovr_ferr", {31'd0, frame_err}, 32'd0);
        for (int i = 0; i < 16; i++) read_byte(8'h10 + 8'(i), $sformatf("ovr_rd%0d", i));
        check("ovr_17th_absent", {31'd0, rvalid}, 32'd0);
        pulse_clr();
        check("ovr_clr", {31'd0, overrun}, 32'd0);

`ifdef UART_PARITY_EN
        parity_en = 1'b1; parity_odd = 1'b1;
        send_frame(8'h01, 1'b1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("par_bad_set", {31'd0, parity_err}, 32'd1);
        check("par_bad_nopush", {31'd0, rvalid}, 32'd0);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        read_byte(8'h01, "par_good");
        parity_en = 1'b0; parity_odd = 1'b0;
        pulse_clr();
`else
        parity_en = 1'b1; parity_odd = 1'b1;
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        read_byte(8'h01, "nopar_frame");
        check("nopar_perr", {31'd0, parity_err}, 32'd0);
        parity_en = 1'b0; parity_odd = 1'b0;
`endif

        // asynchronous reset in the middle of a tx frame, with a byte held in the rx FIFO
        send_frame(8'h77, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
        write_byte(8'h3C);
        repeat (100) @(negedge clk);
        check("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
        check("pre_rst_tx", {31'd0, tx}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'd1);
        check("async_rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("async_rst_busy", {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("post_rst_tx", {31'd0, tx}, 32'd1);
        check("post_rst_wready", {31'd0, wready}, 32'd1);
        check("post_rst_rvalid", {31'd0, rvalid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_ext.md
# uart_ext

Parametrised UART successor: full-duplex serial port with run-time baud divisor, configurable data width, FIFO depth and stop bits, 16× oversampled receiver with 3-sample majority vote, and sticky line-error reporting. It sits between a pin pair (rx/tx) and a valid/ready byte interface, using the same flow-control style as the existing UART.

## Interface
- data_width, 8, character bits, legal 5..9
- fifo_depth, 16, entries per FIFO (rx and tx each), power of 2, ≥2
- div_width, 16, width of baud_div
- clk  in  1  system clock, single clock domain
- rst  in  1  asynchronous, active-high reset
- rx  in  1  serial input, asynchronous to clk
- tx  out  1  serial output, idle high
- baud_div  in  div_width  oversample tick period minus one; tick every baud_div+1 clk cycles
- stop2  in  1  1 = two stop bits on tx, 0 = one; rx always checks first stop bit only
- parity_en  in  1  parity enable (UART_PARITY_EN only)
- parity_odd  in  1  1 = odd, 0 = even (UART_PARITY_EN only)
- rdata  out  data_width  rx FIFO head, valid while rvalid
- rvalid  out  1  rx FIFO non-empty
- rready  in  1  pop rx FIFO when rvalid&&rready
- wdata  in  data_width  tx byte
- wvalid  in  1  push tx FIFO when wvalid&&wready
- wready  out  1  tx FIFO not full
- frame_err  out  1  sticky: stop bit sampled 0
- parity_err  out  1  sticky: parity mismatch
- overrun  out  1  sticky: received character dropped, rx FIFO full
- err_clr  in  1  clears all three sticky flags
- tx_busy  out  1  tx FSM not IDLE or tx FIFO non-empty

## Operation
- Tick generator: counter 0..baud_div, one-cycle tick at terminal count; baud_div=0 → tick every cycle. One bit = 16 ticks.
- Frame config (baud_div effect aside, stop2, parity_en, parity_odd) latched per FSM at leaving IDLE; changes mid-frame take effect next frame.
- RX: rx through 2-flop synchroniser (reset value 1). FSM IDLE→START→DATA→[PARITY]→STOP→IDLE. IDLE: low sample on tick → START, tick counter 0. Each bit value = majority of samples at ticks 7,8,9. START majority 1 → false start, back to IDLE, nothing pushed. DATA: data_width bits, LSB first. STOP: majority 0 → frame_err set, character discarded; parity fail → parity_err set, discarded; valid character with FIFO full → overrun set, discarded; else pushed. FSM returns to IDLE after tick 9 of stop bit (allows early next start).
- TX: FSM IDLE→START→DATA→[PARITY]→STOP1→[STOP2]→IDLE. IDLE with FIFO non-empty: pop on next tick, enter START. Each state lasts 16 ticks. Bits LSB first.
- FIFOs: first-word-fall-through, pointer width clog2(fifo_depth)+1 for full/empty. Simultaneous push and pop on full rx/tx FIFO: both performed. Push to full FIFO impossible externally (wready=0).
- Sticky flags: set has priority over err_clr in same cycle.

## Timing
- Reset values: tx=1, rvalid=0, rdata=0, wready=1, frame_err=parity_err=overrun=0, tx_busy=0; both FSMs IDLE, FIFOs empty, tick counter 0.
- Reset mid-frame: frame aborted, tx returns high immediately (asynchronously), partial rx character lost.
- wdata accepted → start bit on tx within (baud_div+1)+2 cycles; tx_busy high cycle after accept.
- RX: rvalid rises 1 cycle after stop-bit tick 9; rdata stable while rvalid && !rready.
- rx→rvalid total: 2 synchroniser cycles plus frame sampling; bit-period jitter ≤1 tick.

## Configuration
- UART_PARITY_EN defined: parity bit inserted after data on tx when latched parity_en=1, checked on rx; parity_odd selects sense.
- Undefined: no parity logic; parity_en/parity_odd ports present but ignored; parity_err tied 0; frames never contain parity bit.

## Test plan
- baud_div=3, stop2=0, write 0xA5 → tx: 64 cycles low, then bits 1,0,1,0,0,1,0,1 (64 cycles each), 64 cycles high; total 640 cycles; tx_busy falls after.
- tx looped to rx, write 0x00,0xFF,0x5A → rdata reads same three in order, no error flags.
- rx driven with stop bit 0, data 0x3C → no push, frame_err=1; err_clr pulse → frame_err=0.
- fifo_depth=16, rready=0, 17 frames into rx → overrun=1, 16 bytes readable, 17th absent.
- rx low 16 cycles (baud_div=3, <half bit) → false start, rvalid stays 0; reset asserted mid-tx frame → tx=1 same cycle, FIFOs empty.
- UART_PARITY_EN, parity_en=1, parity_odd=1, rx frame 0x01 with parity bit 1 → discarded, parity_err=1; parity bit 0 → rdata=0x01.
